// File: rtl/pipelined_adder_stream_ctrl.sv
// Valid/ready wrapper around a fixed-latency, non-stallable pipelined adder.
// Credits (in flight + buffered) gate acceptance so the output FIFO can never overflow.
module pipelined_adder_stream_ctrl #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = WIDTH,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CW-1:0]    used,
    output logic             ovf_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LATENCY-1:0] vsr_q, vsr_d;
    logic [WIDTH:0]     mem_q [DEPTH];
    logic [WIDTH:0]     mem_d [DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      used_q, used_d;
    logic               ovf_q, ovf_d;

    logic fire, pop, push, full, wr_en;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign add_a   = in_a;
    assign add_b   = in_b;
    assign add_cin = in_cin;

    always_comb begin
        in_ready  = !rst && (used_q < CW'(DEPTH));
        fire      = in_valid & in_ready;
        out_valid = (count_q != '0);
        pop       = out_valid & out_ready;
        push      = vsr_q[LATENCY-1];
        full      = (count_q == CW'(DEPTH));
        // A push into a full FIFO is only legal when the head leaves in the same cycle.
        wr_en     = push && (!full || pop);

        out_sum   = mem_q[rd_ptr_q][WIDTH-1:0];
        out_carry = mem_q[rd_ptr_q][WIDTH];
        used      = used_q;
        ovf_err   = ovf_q;
    end

    always_comb begin
        vsr_d    = (vsr_q << 1) | LATENCY'(fire);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(pop);
        used_d   = used_q + CW'(fire) - CW'(pop);
        ovf_d    = ovf_q | (push && full && !pop);

        if (wr_en) begin
            mem_d[wr_ptr_q] = {add_c, add_s};
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsr_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            used_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            vsr_q    <= vsr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            used_q   <= used_d;
            ovf_q    <= ovf_d;
        end
    end

    // Payload storage needs no reset; out_valid qualifies it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_pipelined_adder_stream_ctrl.sv
// Bench for pipelined_adder_stream_ctrl: two instances (DEPTH 8 and 4) with behavioural
// adders, checked every cycle against a queue-based reference of due times and sums.
module tb_pipelined_adder_stream_ctrl;

    localparam int W   = 4;
    localparam int L   = 4;
    localparam int D8  = 8;
    localparam int D4  = 4;
    localparam int CW8 = 4;
    localparam int CW4 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           iv8 = 0, ir8, icin8 = 0, acin8, ac8, ov8, or8 = 0, ocar8, ovf8;
    logic [W-1:0]   ia8 = 0, ib8 = 0, aa8, ab8, as8, osum8;
    logic [CW8-1:0] used8;
    logic           iv4 = 0, ir4, icin4 = 0, acin4, ac4, ov4, or4 = 0, ocar4, ovf4;
    logic [W-1:0]   ia4 = 0, ib4 = 0, aa4, ab4, as4, osum4;
    logic [CW4-1:0] used4;

    pipelined_adder_stream_ctrl #(.WIDTH(W), .LATENCY(L), .DEPTH(D8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(ia8), .in_b(ib8),
        .in_cin(icin8), .add_a(aa8), .add_b(ab8), .add_cin(acin8), .add_s(as8), .add_c(ac8),
        .out_valid(ov8), .out_ready(or8), .out_sum(osum8), .out_carry(ocar8), .used(used8),
        .ovf_err(ovf8)
    );

    pipelined_adder_stream_ctrl #(.WIDTH(W), .LATENCY(L), .DEPTH(D4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_a(ia4), .in_b(ib4),
        .in_cin(icin4), .add_a(aa4), .add_b(ab4), .add_cin(acin4), .add_s(as4), .add_c(ac4),
        .out_valid(ov4), .out_ready(or4), .out_sum(osum4), .out_carry(ocar4), .used(used4),
        .ovf_err(ovf4)
    );

    // Behavioural adders: sum captured at an edge appears after L edges in total.
    logic [W:0] pipe8 [L];
    logic [W:0] pipe4 [L];
    always @(posedge clk) begin
        pipe8[0] <= {1'b0, aa8} + {1'b0, ab8} + {{W{1'b0}}, acin8};
        pipe4[0] <= {1'b0, aa4} + {1'b0, ab4} + {{W{1'b0}}, acin4};
        for (int i = 1; i < L; i++) begin
            pipe8[i] <= pipe8[i-1];
            pipe4[i] <= pipe4[i-1];
        end
    end
    assign as8 = pipe8[L-1][W-1:0];
    assign ac8 = pipe8[L-1][W];
    assign as4 = pipe4[L-1][W-1:0];
    assign ac4 = pipe4[L-1][W];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W:0] q8_d [$];
    int         q8_t [$];
    logic [W:0] q4_d [$];
    int         q4_t [$];
    int used8_m = 0;
    int used4_m = 0;
    logic f8_last = 0;
    logic f4_last = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check at the falling edge, update the reference across the rising edge.
    task automatic cycle();
        logic f8, p8, f4, p4;
        logic [W:0] e;
        @(negedge clk);
        f8 = iv8 & ir8;
        p8 = ov8 & or8;
        f4 = iv4 & ir4;
        p4 = ov4 & or4;
        check("in_ready8", {31'b0, ir8}, {31'b0, (!rst && used8_m < D8)});
        check("used8", {28'b0, used8}, used8_m);
        check("ovf8", {31'b0, ovf8}, 0);
        check("out_valid8", {31'b0, ov8}, {31'b0, (q8_t.size() != 0 && q8_t[0] <= cyc)});
        check("in_ready4", {31'b0, ir4}, {31'b0, (!rst && used4_m < D4)});
        check("used4", {29'b0, used4}, used4_m);
        check("ovf4", {31'b0, ovf4}, 0);
        check("out_valid4", {31'b0, ov4}, {31'b0, (q4_t.size() != 0 && q4_t[0] <= cyc)});
        if (p8) begin
            if (q8_d.size() == 0) check("pop8_empty", 1, 0);
            else begin
                e = q8_d.pop_front();
                void'(q8_t.pop_front());
                check("data8", {27'b0, ocar8, osum8}, {27'b0, e});
            end
        end
        if (p4) begin
            if (q4_d.size() == 0) check("pop4_empty", 1, 0);
            else begin
                e = q4_d.pop_front();
                void'(q4_t.pop_front());
                check("data4", {27'b0, ocar4, osum4}, {27'b0, e});
            end
        end
        if (f8) begin
            q8_d.push_back({1'b0, ia8} + {1'b0, ib8} + {{W{1'b0}}, icin8});
            q8_t.push_back(cyc + L + 1);
        end
        if (f4) begin
            q4_d.push_back({1'b0, ia4} + {1'b0, ib4} + {{W{1'b0}}, icin4});
            q4_t.push_back(cyc + L + 1);
        end
        used8_m += int'(f8) - int'(p8);
        used4_m += int'(f4) - int'(p4);
        f8_last = f8;
        f4_last = f4;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q8_d.delete(); q8_t.delete(); q4_d.delete(); q4_t.delete();
            used8_m = 0;
            used4_m = 0;
        end
        #1;
    endtask

    task automatic wait_valid8(output int n);
        n = 0;
        while (ov8 !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        int i;
        int guard;

        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        cycle();
        check("reset_ready", {31'b0, ir8}, 1);

        // Single op: 3 + 5.
        or8 = 1; iv8 = 1; ia8 = 4'd3; ib8 = 4'd5; icin8 = 0;
        cycle();
        iv8 = 0;
        wait_valid8(n);
        check("t1_latency", n, L);
        check("t1_sum", {28'b0, osum8}, 8);
        check("t1_carry", {31'b0, ocar8}, 0);
        cycle();
        check("t1_drained", {31'b0, ov8}, 0);
        check("t1_used", {28'b0, used8}, 0);

        // Carry wrap cases.
        iv8 = 1; ia8 = 4'hF; ib8 = 4'h1; icin8 = 1;
        cycle();
        iv8 = 0;
        wait_valid8(n);
        check("t2a_sum", {28'b0, osum8}, 1);
        check("t2a_carry", {31'b0, ocar8}, 1);
        iv8 = 1; ia8 = 4'hF; ib8 = 4'hF; icin8 = 1;
        cycle();
        iv8 = 0;
        wait_valid8(n);
        check("t2b_sum", {28'b0, osum8}, 4'hF);
        check("t2b_carry", {31'b0, ocar8}, 1);
        repeat (3) cycle();

        // Backpressure: exactly DEPTH accepted while the consumer stalls.
        or8 = 0; iv8 = 1; icin8 = 0; i = 0;
        for (int k = 0; k < 20; k++) begin
            ia8 = 4'(i); ib8 = 4'(2 * i);
            cycle();
            if (f8_last) i++;
        end
        check("t3_fires", i, 8);
        check("t3_ready_low", {31'b0, ir8}, 0);
        check("t3_used", {28'b0, used8}, 8);
        or8 = 1; guard = 0;
        while (i < 10 && guard < 40) begin
            ia8 = 4'(i); ib8 = 4'(2 * i);
            cycle();
            if (f8_last) i++;
            guard++;
        end
        check("t3_rest_fired", i, 10);
        iv8 = 0;
        repeat (15) cycle();
        check("t3_empty", {28'b0, used8}, 0);

        // Streaming with a ready consumer.
        iv8 = 1;
        for (int k = 0; k < 100; k++) begin
            ia8 = 4'($urandom); ib8 = 4'($urandom); icin8 = 1'($urandom);
            cycle();
            check("t4_fire", {31'b0, f8_last}, 1);
            if (k >= 10) check("t4_used", {28'b0, used8}, 5);
        end
        iv8 = 0;
        repeat (10) cycle();

        // DEPTH=4: fill completely, then fire and pop together.
        or4 = 0; iv4 = 1; i = 0; guard = 0;
        while (i < 4 && guard < 20) begin
            ia4 = 4'($urandom); ib4 = 4'($urandom); icin4 = 1'($urandom);
            cycle();
            if (f4_last) i++;
            guard++;
        end
        iv4 = 0;
        repeat (8) cycle();
        check("t5_full_used", {29'b0, used4}, 4);
        check("t5_full_ready", {31'b0, ir4}, 0);
        iv4 = 1; or4 = 1;
        ia4 = 4'($urandom); ib4 = 4'($urandom);
        cycle();
        check("t5_credit_back", {31'b0, ir4}, 1);
        for (int k = 0; k < 40; k++) begin
            ia4 = 4'($urandom); ib4 = 4'($urandom); icin4 = 1'($urandom);
            or4 = 1'($urandom_range(0, 1));
            cycle();
        end
        iv4 = 0; or4 = 1;
        repeat (15) cycle();
        check("t5_drained", {29'b0, used4}, 0);

        // Reset with three ops in flight.
        or8 = 1; iv8 = 1;
        for (int k = 0; k < 3; k++) begin
            ia8 = 4'($urandom); ib8 = 4'($urandom); icin8 = 1'($urandom);
            cycle();
        end
        iv8 = 0; rst = 1;
        cycle();
        rst = 0;
        repeat (8) cycle();
        check("t6_used", {28'b0, used8}, 0);
        iv8 = 1; ia8 = 4'd7; ib8 = 4'd6; icin8 = 1;
        cycle();
        iv8 = 0;
        wait_valid8(n);
        check("t6_latency", n, L);
        check("t6_sum", {27'b0, ocar8, osum8}, 14);
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
